// File: rtl/tagger_req_gen.sv
// tagger_req_gen: walks a table of address regions. For each region it writes
//   one tagged data beat (AW, W, B) and can optionally read that beat back
//   (AR, R) and compare it against what was written.
// Latency: one state per AXI handshake, with no bubble between phases. DONE
//   and TIMEOUT each take one cycle before the block returns to IDLE.
// Backpressure: each valid and its payload stay held until the slave accepts
//   them. A phase that stalls for TIMEOUT_CYCLES-1 cycles aborts the walk.
//
// Build option: define TAGGER_REQ_GEN_READBACK_EN to include the AR/R states
// and the readback compare. Each region then counts as 2 transactions
// instead of 1.
//
// Ports:
//   clk_i, rst_i     clock (rising edge); asynchronous active-high reset
//   start_i          starts a walk; sampled only while idle
//   addr_conf_i      region table; .addr is the probe address of each region
//   mst_req_o        AXI master request toward the tagger slave port
//   mst_resp_i       AXI slave response
//   busy_o           high in every state except IDLE
//   done_o           sticky walk-complete flag; cleared by the next start
//   timeout_o        sticky handshake-timeout flag
//   resp_err_o       sticky flag: non-OKAY B/R response or readback mismatch
//   txn_cnt_o        completed transactions since the last start (wraps)

package tagger_req_gen_pkg;

    // These types give a default AXI4 layout that matches AXI_DATA_WIDTH=64.
    // An integrator passes its own types through the type parameters.
    // Those types must keep the same field names.
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned USER_W = 1;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        addr_t             addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [USER_W-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

    typedef struct packed {
        addr_t      addr;
        addr_t      size;
        logic [7:0] patid;
    } addr_conf_t;

endpackage

module tagger_req_gen #(
    parameter int unsigned NUM_ADDR_CONF  = 4,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter type axi_req_t   = tagger_req_gen_pkg::axi_req_t,
    parameter type axi_resp_t  = tagger_req_gen_pkg::axi_resp_t,
    parameter type axi_addr_t  = tagger_req_gen_pkg::addr_t,
    parameter type addr_conf_t = tagger_req_gen_pkg::addr_conf_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  addr_conf_t  addr_conf_i [NUM_ADDR_CONF],
    output axi_req_t    mst_req_o,
    input  axi_resp_t   mst_resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic        resp_err_o,
    output logic [15:0] txn_cnt_o
);

    localparam int unsigned IDX_W = (NUM_ADDR_CONF > 1) ? $clog2(NUM_ADDR_CONF) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ADDR_CONF - 1);
    localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;
    // The wait counter gets this value on the stalled cycle that aborts the phase.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       txn_cnt_q, txn_cnt_d;
    logic [15:0]       wait_q, wait_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              resp_err_q, resp_err_d;

    logic              hs;         // the current phase's handshake fires this cycle
    logic              step;       // this region has finished; go to the next one
    logic              waiting;    // in a phase that waits for the slave
    logic [15:0]       wait_inc;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    axi_req_t          mst_req;

    // The tag is {region index, transaction count}, zero-extended to the bus width.
    always_comb begin
        wdata = '0;
        wdata[IDX_W+15:0] = {idx_q, txn_cnt_q};
    end

`ifdef TAGGER_REQ_GEN_READBACK_EN
    // Holds the word written to this region. The transaction count moves on
    // at B, so the readback compare cannot use the live tag.
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      rd_mismatch;

    assign rd_mismatch = (mst_resp_i.r.resp != 2'b00) || (mst_resp_i.r.data != wdata_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdata_q <= '0;
        end else begin
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        wdata_d = wdata_q;
        if (state_q == ST_W && mst_resp_i.w_ready) begin
            wdata_d = wdata;
        end
    end
`endif

    assign wait_inc = wait_q + 16'd1;
    assign waiting  = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B) ||
                      (state_q == ST_AR) || (state_q == ST_R);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        txn_cnt_d  = txn_cnt_q;
        wait_d     = wait_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        resp_err_d = resp_err_q;
        hs         = 1'b0;
        step       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_AW;
                    idx_d      = '0;
                    txn_cnt_d  = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    resp_err_d = 1'b0;
                end
            end
            ST_AW: begin
                hs = mst_resp_i.aw_ready;
                if (hs) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                hs = mst_resp_i.w_ready;
                if (hs) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                hs = mst_resp_i.b_valid;
                if (hs) begin
                    txn_cnt_d = txn_cnt_q + 16'd1;
                    if (mst_resp_i.b.resp != 2'b00) begin
                        resp_err_d = 1'b1;
                    end
`ifdef TAGGER_REQ_GEN_READBACK_EN
                    state_d = ST_AR;
`else
                    step = 1'b1;
`endif
                end
            end
`ifdef TAGGER_REQ_GEN_READBACK_EN
            ST_AR: begin
                hs = mst_resp_i.ar_ready;
                if (hs) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                // A beat without last is still consumed (r_ready stays high).
                // Only the last beat finishes the phase.
                hs = mst_resp_i.r_valid && mst_resp_i.r.last;
                if (hs) begin
                    txn_cnt_d = txn_cnt_q + 16'd1;
                    if (rd_mismatch) begin
                        resp_err_d = 1'b1;
                    end
                    step = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_TIMEOUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (step) begin
            if (idx_q == LAST_IDX) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_AW;
            end
        end

        // The wait counter restarts on every state change. A stalled phase that
        // brings the counter to TIMEOUT_CYCLES-1 aborts the walk. A handshake in
        // the same cycle still wins.
        if (waiting && !hs) begin
            if (wait_inc == WAIT_LAST) begin
                state_d   = ST_TIMEOUT;
                timeout_d = 1'b1;
                wait_d    = '0;
            end else begin
                wait_d = wait_inc;
            end
        end else begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            txn_cnt_q  <= '0;
            wait_q     <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            txn_cnt_q  <= txn_cnt_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Request outputs. Valids are decoded directly from the state register, so
    // reset drops them as soon as it is asserted. Payloads depend only on
    // idx_q, txn_cnt_q and the table, and none of these change within a phase.
    always_comb begin
        mst_req = '0;

        mst_req.aw.id[IDX_W-1:0] = idx_q;
        mst_req.aw.addr          = axi_addr_t'(addr_conf_i[idx_q].addr);
        mst_req.aw.len           = 8'd0;
        mst_req.aw.size          = AXI_SIZE;
        mst_req.aw.burst         = BURST_INCR;
        mst_req.ar               = mst_req.aw;

        mst_req.w.data = wdata;
        mst_req.w.strb = '1;
        mst_req.w.last = 1'b1;

        mst_req.aw_valid = (state_q == ST_AW);
        mst_req.w_valid  = (state_q == ST_W);
        mst_req.b_ready  = (state_q == ST_B);
`ifdef TAGGER_REQ_GEN_READBACK_EN
        mst_req.ar_valid = (state_q == ST_AR);
        mst_req.r_ready  = (state_q == ST_R);
`endif
    end

    assign mst_req_o  = mst_req;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;
    assign resp_err_o = resp_err_q;
    assign txn_cnt_o  = txn_cnt_q;

    // Table and response fields this block does not use.
    logic [NUM_ADDR_CONF-1:0] unused_conf;
    logic                     unused_resp;

    for (genvar k = 0; k < NUM_ADDR_CONF; k++) begin : g_unused_conf
        assign unused_conf[k] = ^{addr_conf_i[k].size, addr_conf_i[k].patid};
    end
    assign unused_resp = ^mst_resp_i;

endmodule

// File: tb/tb_tagger_req_gen.sv
// Bench for tagger_req_gen. An echo slave model answers the DUT's requests.
// The stimulus pushes each expected beat into a queue before it starts a walk.
// A monitor pops a queue entry at every handshake and compares it with the
// beat on the bus. Flag checks are made against hand-computed constants.
module tb_tagger_req_gen;
    import tagger_req_gen_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int TO = 16;

    localparam logic [63:0] ADDR [N] = '{64'h1000, 64'h2040, 64'h3080, 64'h40C0};
`ifdef TAGGER_REQ_GEN_READBACK_EN
    localparam int TPR = 2;
    // Tag {region, count}. The count before each region's write is 2*region.
    localparam logic [63:0] WDATA [N] = '{64'h0, 64'h1_0002, 64'h2_0004, 64'h3_0006};
`else
    localparam int TPR = 1;
    localparam logic [63:0] WDATA [N] = '{64'h0, 64'h1_0001, 64'h2_0002, 64'h3_0003};
`endif

    logic        clk;
    logic        rst;
    logic        start;
    addr_conf_t  conf [N];
    axi_req_t    req;
    axi_resp_t   resp;
    logic        busy, done, tmo, rerr;
    logic [15:0] cnt;

    int total = 0;
    int bad   = 0;

    tagger_req_gen #(
        .NUM_ADDR_CONF (N),
        .AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .addr_conf_i(conf),
        .mst_req_o  (req),
        .mst_resp_i (resp),
        .busy_o     (busy),
        .done_o     (done),
        .timeout_o  (tmo),
        .resp_err_o (rerr),
        .txn_cnt_o  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_stall_left = 0;
    logic [7:0]  b_err_id = 8'hFF;
    bit          b_never = 1'b0;
    logic [63:0] mem [logic [63:0]];
    logic [63:0] cur_addr = '0;
    logic [7:0]  cur_id = '0;
    bit          b_pend = 1'b0;
    bit          r_pend = 1'b0;
    logic [63:0] r_addr = '0;
    logic [7:0]  r_id = '0;

    initial begin
        resp = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                resp   = '0;
                b_pend = 1'b0;
                r_pend = 1'b0;
            end else begin
                resp.aw_ready = 1'b0;
                if (req.aw_valid) begin
                    if (aw_stall_left > 0) begin
                        aw_stall_left--;
                    end else begin
                        resp.aw_ready = 1'b1;
                        cur_addr = req.aw.addr;
                        cur_id   = req.aw.id;
                    end
                end
                resp.b_valid = b_pend && !b_never;
                resp.b.id    = cur_id;
                resp.b.resp  = (cur_id == b_err_id) ? 2'b10 : 2'b00;
                if (resp.b_valid && req.b_ready) b_pend = 1'b0;
                resp.w_ready = 1'b1;
                if (req.w_valid) begin
                    mem[cur_addr] = req.w.data;
                    b_pend = 1'b1;
                end
                resp.r_valid = r_pend;
                resp.r.id    = r_id;
                resp.r.data  = mem.exists(r_addr) ? mem[r_addr] : 64'h0;
                resp.r.resp  = 2'b00;
                resp.r.last  = 1'b1;
                if (r_pend && req.r_ready) r_pend = 1'b0;
                resp.ar_ready = 1'b1;
                if (req.ar_valid) begin
                    r_pend = 1'b1;
                    r_addr = req.ar.addr;
                    r_id   = req.ar.id;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  id;
        int          cycles;
    } beat_t;

    beat_t       exp_aw [$];
    beat_t       exp_ar [$];
    logic [63:0] exp_w  [$];
    int          aw_run = 0;
    int          aw_hs = 0;
    int          w_hs = 0;
    int          ar_cycles = 0;
    int          b_rdy_run = 0;
    bit          prev_aw_stall = 1'b0;
    axi_req_t    prev_req = '0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_aw.delete();
                exp_ar.delete();
                exp_w.delete();
                aw_run = 0;
                aw_hs = 0;
                w_hs = 0;
                prev_aw_stall = 1'b0;
            end else begin
                if (prev_aw_stall) begin
                    check("aw_valid_hold", req.aw_valid, 1);
                    check("aw_payload_hold", req.aw == prev_req.aw, 1);
                end
                if (req.aw_valid || req.w_valid) check("aw_w_overlap", req.aw_valid & req.w_valid, 0);
                if (req.b_ready) b_rdy_run++;
                if (req.aw_valid) begin
                    aw_run++;
                    if (resp.aw_ready) begin
                        check("aw_expected", exp_aw.size() != 0, 1);
                        if (exp_aw.size() != 0) begin
                            beat_t e;
                            e = exp_aw.pop_front();
                            check("aw_addr", req.aw.addr, e.addr);
                            check("aw_id", req.aw.id, e.id);
                            check("aw_len", req.aw.len, 0);
                            check("aw_size", req.aw.size, 3);
                            check("aw_burst", req.aw.burst, 1);
                            check("aw_valid_cycles", aw_run, e.cycles);
                        end
                        aw_run = 0;
                        aw_hs++;
                        b_rdy_run = 0;
                    end
                end
                if (req.w_valid) begin
                    check("w_after_aw", aw_hs > w_hs, 1);
                    check("w_expected", exp_w.size() != 0, 1);
                    if (exp_w.size() != 0) begin
                        logic [63:0] d;
                        d = exp_w.pop_front();
                        check("w_data", req.w.data, d);
                        check("w_strb", req.w.strb, 64'hFF);
                        check("w_last", req.w.last, 1);
                    end
                    w_hs++;
                end
                if (req.ar_valid) begin
                    ar_cycles++;
                    check("ar_expected", exp_ar.size() != 0, 1);
                    if (exp_ar.size() != 0) begin
                        beat_t e;
                        e = exp_ar.pop_front();
                        check("ar_addr", req.ar.addr, e.addr);
                        check("ar_id", req.ar.id, e.id);
                    end
                end
                prev_aw_stall = req.aw_valid && !resp.aw_ready;
                prev_req = req;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_walk(input int stall0, input int regions);
        for (int i = 0; i < regions; i++) begin
            beat_t b;
            b.addr   = ADDR[i];
            b.id     = 8'(i);
            b.cycles = (i == 0) ? stall0 + 1 : 1;
            exp_aw.push_back(b);
            exp_w.push_back(WDATA[i]);
`ifdef TAGGER_REQ_GEN_READBACK_EN
            b.cycles = 1;
            exp_ar.push_back(b);
`endif
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && !tmo && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_in_budget"}, done, 1);
    endtask

    task automatic check_walk_end(input string name, input logic exp_err);
        check({name, "_busy_in_done"}, busy, 1);
        check({name, "_txn_cnt"}, cnt, N * TPR);
        check({name, "_resp_err"}, rerr, exp_err);
        check({name, "_timeout"}, tmo, 0);
        @(negedge clk);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_done_sticky"}, done, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            conf[i].addr  = ADDR[i];
            conf[i].size  = 64'h40;
            conf[i].patid = 8'(i + 1);
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", tmo, 0);
        check("rst_resp_err", rerr, 0);
        check("rst_txn_cnt", cnt, 0);
        check("rst_valids", {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}, 0);
        rst = 1'b0;

        // Plain walk; a start pulse in the middle of the walk must be ignored.
        push_walk(0, N);
        pulse_start();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("walk");
        check_walk_end("walk", 1'b0);

        // AW held off for 5 cycles on region 0.
        aw_stall_left = 5;
        push_walk(5, N);
        pulse_start();
        check("start_clears_done", done, 0);
        check("start_sets_busy", busy, 1);
        wait_done("stall");
        check_walk_end("stall", 1'b0);

        // SLVERR on region 1's B response.
        b_err_id = 8'd1;
        push_walk(0, N);
        pulse_start();
        wait_done("berr");
        check_walk_end("berr", 1'b1);
        b_err_id = 8'hFF;

        // B never arrives.
        b_never = 1'b1;
        push_walk(0, 1);
        pulse_start();
        begin
            int n = 0;
            while (!tmo && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("to_flag", tmo, 1);
        check("to_b_ready_cycles", b_rdy_run, TO - 1);
        check("to_state_valids", {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}, 0);
        @(negedge clk);
        check("to_busy_after", busy, 0);
        check("to_done", done, 0);
        check("to_sticky", tmo, 1);
        check("to_resp_err_cleared", rerr, 0);
        check("to_txn_cnt", cnt, 0);
        b_never = 1'b0;

        // Reset during W, then a fresh walk.
        push_walk(0, N);
        pulse_start();
        begin
            int n = 0;
            while (!req.w_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("rw_reached_w", req.w_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rw_w_valid_dropped", req.w_valid, 0);
        check("rw_valids", {req.aw_valid, req.b_ready, req.ar_valid, req.r_ready}, 0);
        check("rw_busy", busy, 0);
        check("rw_flags", {done, tmo, rerr}, 0);
        check("rw_txn_cnt", cnt, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_walk(0, N);
        pulse_start();
        wait_done("restart");
        check_walk_end("restart", 1'b0);

        repeat (2) @(negedge clk);
        check("aw_queue_drained", exp_aw.size(), 0);
        check("w_queue_drained", exp_w.size(), 0);
        check("ar_queue_drained", exp_ar.size(), 0);
`ifndef TAGGER_REQ_GEN_READBACK_EN
        check("no_ar_valid", ar_cycles, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tagger_req_gen.md
TAGGER_REQ_GEN -- requirements
Module: tagger_req_gen

Interface
REQ-001 SHALL have parameter NUM_ADDR_CONF, default 4, meaning the number of address-config regions walked.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, meaning the W/R data width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum wait cycles per handshake.
REQ-004 SHALL have parameters axi_req_t, axi_resp_t, axi_addr_t and addr_conf_t, each default logic; addr_conf_t has fields addr, size, patid.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port start_i, input, 1 bit: start pulse, sampled only in IDLE.
REQ-008 SHALL have port addr_conf_i, input, addr_conf_t[NUM_ADDR_CONF]: region table; addr is the probe address.
REQ-009 SHALL have port mst_req_o, output, axi_req_t: AXI master request toward the tagger slave port.
REQ-010 SHALL have port mst_resp_i, input, axi_resp_t: AXI response.
REQ-011 SHALL have ports busy_o and done_o, output, 1 bit each: running; sticky completion.
REQ-012 SHALL have ports timeout_o and resp_err_o, output, 1 bit each: sticky timeout; sticky non-OKAY B/R response.
REQ-013 SHALL have port txn_cnt_o, output, 16 bits: number of completed transactions.

Function
REQ-014 SHALL implement the FSM states IDLE, AW, W, B, AR, R, DONE and TIMEOUT.
REQ-015 IDLE SHALL move to AW on start_i=1, clearing region index i, txn_cnt_o, done_o, timeout_o and resp_err_o.
REQ-016 AW SHALL drive aw_valid=1 with addr=addr_conf_i[i].addr, id=i, len=0, size=log2(AXI_DATA_WIDTH/8), burst=INCR, user=0, and move to W on aw_ready.
REQ-017 W SHALL drive w_valid=1, last=1, strb all ones and data = {i, txn_cnt_o} zero-extended, and move to B on w_ready.
REQ-018 B SHALL drive b_ready=1; on b_valid it SHALL increment txn_cnt_o, set resp_err_o if resp is not 0, then go to AR (readback enabled) or to the next region.
REQ-019 AR SHALL drive ar_valid=1 with the same fields as the AW beat and move to R on ar_ready.
REQ-020 R SHALL drive r_ready=1; on r_valid && r.last it SHALL increment txn_cnt_o and set resp_err_o if resp is non-zero or data differs from the written data.
REQ-021 The next-region step SHALL increment i; when i=NUM_ADDR_CONF-1 is completed it SHALL enter DONE instead.
REQ-022 DONE SHALL set done_o=1 and return to IDLE in the next cycle; done_o SHALL hold until the next accepted start_i.
REQ-023 Valid signals and payloads SHALL stay stable from assertion until the handshake; AW and W SHALL never be valid in the same cycle.
REQ-024 A 16-bit wait counter SHALL clear on every state change and increment while in AW, W, B, AR or R without a handshake.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES-1, the block SHALL enter TIMEOUT, set timeout_o, and deassert all valid and ready signals.
REQ-026 TIMEOUT SHALL return to IDLE in the next cycle.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 start_i SHALL be ignored outside IDLE.
REQ-029 txn_cnt_o SHALL wrap modulo 2^16.

Reset
REQ-030 While rst_i=1, the FSM SHALL be in IDLE and all valid/ready outputs, busy_o, done_o, timeout_o, resp_err_o, txn_cnt_o, i and the wait counter SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL drop all valid outputs asynchronously; no partial transaction is resumed after reset.

Configuration
REQ-032 With macro TAGGER_REQ_GEN_READBACK_EN defined, the AR and R states and the data compare SHALL be compiled in, giving 2 transactions per region.
REQ-033 Without TAGGER_REQ_GEN_READBACK_EN, B SHALL go directly to the next region, ar_valid and r_ready SHALL be tied to 0, and there is 1 transaction per region.

Verification
REQ-034 Readback enabled, 4 regions, always-ready echo slave, start_i pulse -> AW addresses equal addr_conf_i[0..3].addr in order; done_o=1, txn_cnt_o=8, resp_err_o=0.
REQ-035 Readback disabled, same stimulus -> no ar_valid ever; done_o=1, txn_cnt_o=4.
REQ-036 aw_ready held low for 5 cycles -> aw_valid and the AW payload stay stable for 6 cycles; no W beat before the AW handshake.
REQ-037 Slave returns B resp=2'b10 on region 1 -> resp_err_o=1 sticky, walk continues, done_o=1.
REQ-038 TIMEOUT_CYCLES=16, slave never asserts b_valid -> timeout_o=1 after 15 wait cycles in B, then IDLE, busy_o=0, done_o=0.
REQ-039 rst_i asserted during W -> w_valid=0 immediately, all outputs 0; a new start_i restarts at region 0 with txn_cnt_o=0.
